if_id_queue: RTL

- Parametrised successor to the single-entry IF/ID pipeline register.
- DEPTH-entry instruction queue that decouples the fetch stage from decode. It carries {pc4, instruction} pairs with valid/ready handshakes on both sides.
- Supports a branch flush that squashes all queued entries.
- Decode sees a NOP bubble whenever the queue is empty.
- Sits between the IF stage and ID stage of the pipelined CPU.

---
 rtl/if_id_queue_pkg.sv | 8 +
 rtl/if_id_queue.sv | 75 +++++++
 2 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared constants for the fetch/decode boundary: reset polarity, stall encoding and bubble values.
package if_id_queue_pkg;
   localparam logic        RST_ENABLED       = 1'b1;
   localparam logic        RUN               = 1'b0;
   localparam logic        STOP              = 1'b1;
   localparam logic [31:0] ZERO_32BIT        = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/if_id_queue.sv
// DEPTH-entry IF->ID instruction queue; a pushed entry is visible on id_* one edge later (no bypass).
// if_ready = !full (registered state only); is_branch flushes everything; an empty queue shows a NOP bubble.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int unsigned      XLEN      = 32,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       if_valid,
   input  logic [XLEN-1:0]            if_pc4,
   input  logic [XLEN-1:0]            if_instruction,
   output logic                       if_ready,
   input  logic                       id_stall,
   input  logic                       is_branch,
   output logic                       id_valid,
   output logic [XLEN-1:0]            id_pc4,
   output logic [XLEN-1:0]            id_instruction,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   logic [XLEN-1:0] pc4_mem   [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            push;
   logic            pop;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign if_ready = !full;
   assign id_valid = !empty;

   assign push = if_valid & if_ready;
   assign pop  = id_valid & (id_stall == RUN);

   // Head is masked so decode sees a clean bubble rather than stale storage.
   assign id_pc4         = empty ? '0        : pc4_mem[rd_ptr];
   assign id_instruction = empty ? NOP_INSTR : instr_mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RST_ENABLED) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (is_branch) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // Storage is never reset; only the pointers and count define what is live.
   always_ff @(posedge clk) begin
      if (push && !is_branch) begin
         pc4_mem[wr_ptr]   <= if_pc4;
         instr_mem[wr_ptr] <= if_instruction;
      end
   end
endmodule
